// File: rtl/spi3w_write_sequencer_if.sv
// rtl/spi3w_write_sequencer_if.sv - command and serial-writer control bundle for the 3-wire write sequencer
interface spi3w_write_sequencer_if;
  logic       I_cmd_valid;
  logic       O_cmd_ready;
  logic       I_cmd_len;
  logic [7:0] I_cmd_byte0;
  logic [7:0] I_cmd_byte1;
  logic [7:0] I_cmd_byte2;
  logic       O_wr_en;
  logic       O_1st_byte;
  logic       O_2nd_byte;
  logic       O_last_byte;
  logic [7:0] O_data_8;
  logic       I_1Byte_done;
  logic       I_lastByte_done;
  logic       O_busy;
  logic       O_done;
  logic       O_timeout;

  modport master (
    input  I_cmd_valid, I_cmd_len, I_cmd_byte0, I_cmd_byte1, I_cmd_byte2,
    input  I_1Byte_done, I_lastByte_done,
    output O_cmd_ready, O_wr_en, O_1st_byte, O_2nd_byte, O_last_byte, O_data_8,
    output O_busy, O_done, O_timeout
  );

  modport slave (
    output I_cmd_valid, I_cmd_len, I_cmd_byte0, I_cmd_byte1, I_cmd_byte2,
    output I_1Byte_done, I_lastByte_done,
    input  O_cmd_ready, O_wr_en, O_1st_byte, O_2nd_byte, O_last_byte, O_data_8,
    input  O_busy, O_done, O_timeout
  );
endinterface

// File: rtl/spi3w_write_sequencer.sv
// rtl/spi3w_write_sequencer.sv - sequences one 2/3-byte write through the 3-wire serial byte writer
module spi3w_write_sequencer #(
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                          I_clk,
  input  logic                          I_rst,
  spi3w_write_sequencer_if.master       bus
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, GAP} state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic          len_q, len_d;
  logic [7:0]    byte0_q, byte0_d;
  logic [7:0]    byte1_q, byte1_d;
  logic [7:0]    byte2_q, byte2_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          d1_prev_q, d1_prev_d;
  logic          dl_prev_q, dl_prev_d;
  logic          done_q, done_d;
  logic          timeout_q, timeout_d;

  logic          edge_1byte;
  logic          edge_last;
  logic          tmo_expire;
  logic          gap_end;

  // A level already high from the previous transaction is history, not an edge.
  assign edge_1byte = bus.I_1Byte_done & ~d1_prev_q;
  assign edge_last  = bus.I_lastByte_done & ~dl_prev_q;
  assign tmo_expire = (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
  assign gap_end    = (gap_cnt_q == GW'(GAP_CYC));

  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    len_d     = len_q;
    byte0_d   = byte0_q;
    byte1_d   = byte1_q;
    byte2_d   = byte2_q;
    tmo_cnt_d = tmo_cnt_q + TW'(1);
    gap_cnt_d = gap_cnt_q;
    d1_prev_d = bus.I_1Byte_done;
    dl_prev_d = bus.I_lastByte_done;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_cnt_d = '0;
        gap_cnt_d = '0;
        ready_d   = 1'b1;
        if (bus.I_cmd_valid && ready_q) begin
          len_d   = bus.I_cmd_len;
          byte0_d = bus.I_cmd_byte0;
          byte1_d = bus.I_cmd_byte1;
          byte2_d = bus.I_cmd_byte2;
          ready_d = 1'b0;
          state_d = B0;
        end
      end
      B0: begin
        if (edge_1byte) begin
          state_d   = len_q ? B1 : B2;
          tmo_cnt_d = '0;
        end else if (tmo_expire) begin
          state_d   = GAP;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end
      end
      B1: begin
        if (edge_1byte) begin
          state_d   = B2;
          tmo_cnt_d = '0;
        end else if (tmo_expire) begin
          state_d   = GAP;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end
      end
      B2: begin
        if (edge_last) begin
          state_d   = GAP;
          done_d    = 1'b1;
          gap_cnt_d = '0;
        end else if (tmo_expire) begin
          state_d   = GAP;
          timeout_d = 1'b1;
          gap_cnt_d = '0;
        end
      end
      GAP: begin
        tmo_cnt_d = '0;
        // The cycle carrying done/timeout is the first gap cycle.
        if (gap_end) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      len_q     <= 1'b0;
      byte0_q   <= '0;
      byte1_q   <= '0;
      byte2_q   <= '0;
      tmo_cnt_q <= '0;
      gap_cnt_q <= '0;
      d1_prev_q <= 1'b0;
      dl_prev_q <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      len_q     <= len_d;
      byte0_q   <= byte0_d;
      byte1_q   <= byte1_d;
      byte2_q   <= byte2_d;
      tmo_cnt_q <= tmo_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      d1_prev_q <= d1_prev_d;
      dl_prev_q <= dl_prev_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Writer controls decode straight from state so strobe and data switch on the same edge.
  assign bus.O_cmd_ready = ready_q;
  assign bus.O_wr_en     = (state_q == B0) || (state_q == B1) || (state_q == B2);
  assign bus.O_1st_byte  = (state_q == B0);
  assign bus.O_2nd_byte  = (state_q == B1);
  assign bus.O_last_byte = (state_q == B2);
  assign bus.O_busy      = (state_q != IDLE);
  assign bus.O_done      = done_q;
  assign bus.O_timeout   = timeout_q;

  always_comb begin
    case (state_q)
      B0:      bus.O_data_8 = byte0_q;
      B1:      bus.O_data_8 = byte1_q;
      B2:      bus.O_data_8 = byte2_q;
      default: bus.O_data_8 = 8'h00;
    endcase
  end

endmodule
